// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Brief    : Buffers A/B operands, streams them into systolic_array, flushes
//            it and captures the H*W results into a readable buffer.
// Revision : 1.0
// ============================================================================
module systolic_feeder #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2,
  localparam int c_a_n    = array_height_p * depth_p,
  localparam int c_b_n    = depth_p * array_width_p,
  localparam int c_ld_n   = (c_a_n > c_b_n) ? c_a_n : c_b_n,
  localparam int c_ld_aw  = (c_ld_n > 1) ? $clog2(c_ld_n) : 1,
  localparam int c_res_n  = array_height_p * array_width_p,
  localparam int c_res_aw = (c_res_n > 1) ? $clog2(c_res_n) : 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                ld_v_i,
  input  logic                ld_b_i,
  input  logic [c_ld_aw-1:0]  ld_addr_i,
  input  logic [width_p-1:0]  ld_data_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic [c_res_aw-1:0] rd_addr_i,
  output logic [width_p-1:0]  rd_data_o,
  output logic                valid_o,
  output logic [width_p-1:0]  data_o,
  input  logic                ready_i,
  input  logic                idle_i,
  output logic                flush_o,
  input  logic                valid_i,
  input  logic [width_p-1:0]  data_i,
  output logic                yumi_o
);

  localparam int c_el_n = array_width_p + array_height_p;
  localparam int c_el_w = $clog2(c_el_n);
  localparam int c_ph_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [c_el_w-1:0]   c_el_last  = c_el_w'(c_el_n - 1);
  localparam logic [c_ph_w-1:0]   c_ph_last  = c_ph_w'(depth_p - 1);
  localparam logic [c_res_aw-1:0] c_res_last = c_res_aw'(c_res_n - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_WAIT    = 3'd2,
    S_FLUSH   = 3'd3,
    S_COLLECT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  logic [width_p-1:0]  r_a_buf [c_ld_n];
  logic [width_p-1:0]  r_b_buf [c_ld_n];
  logic [width_p-1:0]  r_res   [c_res_n];
  logic [c_ph_w-1:0]   r_phase;
  logic [c_el_w-1:0]   r_elem;
  logic [c_res_aw-1:0] r_res_idx;
  logic                r_wait_armed;

  logic               w_accept;
  logic               w_feed_xfer;
  logic               w_feed_last;
  logic               w_col_xfer;
  logic [c_ld_aw-1:0] w_a_idx;
  logic [c_ld_aw-1:0] w_b_idx;
  logic [width_p-1:0] w_data;

  assign w_accept    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_feed_xfer = (r_state == S_FEED) && ready_i;
  assign w_feed_last = w_feed_xfer && (r_phase == c_ph_last) && (r_elem == c_el_last);
  assign w_col_xfer  = (r_state == S_COLLECT) && valid_i;

  // Phases walk k downward (k = K-1-p); within a phase the B row precedes the A column.
  always_comb begin
    w_b_idx = c_ld_aw'((depth_p - 1 - int'(r_phase)) * array_width_p + int'(r_elem));
    w_a_idx = c_ld_aw'((int'(r_elem) - array_width_p) * depth_p
                       + (depth_p - 1 - int'(r_phase)));
    w_data  = '0;
    if (r_state == S_FEED) begin
      if (int'(r_elem) < array_width_p) w_data = r_b_buf[w_b_idx];
      else                              w_data = r_a_buf[w_a_idx];
    end
  end

  assign data_o    = w_data;
  assign rd_data_o = r_res[rd_addr_i];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    valid_o     = 1'b0;
    flush_o     = 1'b0;
    yumi_o      = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_FEED;
      S_FEED: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
        if (w_feed_last) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        // The array's idle flag may still be stale in the first cycle after feeding.
        if (r_wait_armed && idle_i) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy_o      = 1'b1;
        flush_o     = 1'b1;
        w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        busy_o = 1'b1;
        yumi_o = valid_i;
        if (valid_i && (r_res_idx == c_res_last)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) w_state_nxt = S_FEED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_phase      <= '0;
      r_elem       <= '0;
      r_res_idx    <= '0;
      r_wait_armed <= 1'b0;
      for (int i = 0; i < c_ld_n; i++) begin
        r_a_buf[i] <= '0;
        r_b_buf[i] <= '0;
      end
      for (int i = 0; i < c_res_n; i++) r_res[i] <= '0;
    end else begin
      r_wait_armed <= (r_state == S_WAIT);
      if (w_accept && ld_v_i) begin
        if (ld_b_i) begin
          if (int'(ld_addr_i) < c_b_n) r_b_buf[ld_addr_i] <= ld_data_i;
        end else begin
          if (int'(ld_addr_i) < c_a_n) r_a_buf[ld_addr_i] <= ld_data_i;
        end
      end
      if (w_accept && start_i) begin
        r_phase   <= '0;
        r_elem    <= '0;
        r_res_idx <= '0;
      end
      if (w_feed_xfer) begin
        if (r_elem == c_el_last) begin
          r_elem  <= '0;
          r_phase <= (r_phase == c_ph_last) ? '0 : r_phase + 1'b1;
        end else begin
          r_elem <= r_elem + 1'b1;
        end
      end
      if (w_col_xfer) begin
        r_res[r_res_idx] <= data_i;
        r_res_idx        <= (r_res_idx == c_res_last) ? '0 : r_res_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Brief    : Directed bench for systolic_feeder acting as the systolic array.
// Revision : 1.0
// ============================================================================
module tb_systolic_feeder;
  localparam int W  = 2;
  localparam int H  = 2;
  localparam int K  = 2;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          ld_v_i = 1'b0, ld_b_i = 1'b0, start_i = 1'b0;
  logic [1:0]    ld_addr_i = '0;
  logic [DW-1:0] ld_data_i = '0;
  logic          busy_o, done_o, valid_o, flush_o, yumi_o;
  logic [1:0]    rd_addr_i = '0;
  logic [DW-1:0] rd_data_o, data_o;
  logic          ready_i = 1'b1, idle_i = 1'b1, valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;

  systolic_feeder #(
    .width_p(DW), .array_width_p(W), .array_height_p(H), .depth_p(K)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .ld_v_i(ld_v_i), .ld_b_i(ld_b_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .idle_i(idle_i),
    .flush_o(flush_o), .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int ma [H][K];
  int mb [K][W];
  int exp_c [4] = '{7, 10, 15, 22};
  logic [DW-1:0] q_feed [$];
  logic [DW-1:0] q_res  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected feed stream and array results derived from the operand model.
  task automatic push_expected();
    for (int p = 0; p < K; p++) begin
      int k;
      k = K - 1 - p;
      for (int e = 0; e < W + H; e++) begin
        if (e < W) q_feed.push_back(DW'(mb[k][e]));
        else       q_feed.push_back(DW'(ma[e-W][k]));
      end
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < K; kk++) s += ma[r][kk] * mb[kk][c];
        q_res.push_back(DW'(s));
      end
  endtask

  task automatic load_all(input bit start_last);
    for (int i = 0; i < H*K; i++) begin
      @(negedge clk_i);
      ld_v_i = 1'b1; ld_b_i = 1'b0; ld_addr_i = 2'(i); ld_data_i = DW'(ma[i/K][i%K]);
    end
    for (int i = 0; i < K*W; i++) begin
      @(negedge clk_i);
      ld_v_i = 1'b1; ld_b_i = 1'b1; ld_addr_i = 2'(i); ld_data_i = DW'(mb[i/W][i%W]);
      start_i = start_last && (i == K*W-1);
    end
    @(negedge clk_i);
    ld_v_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic check_start();
    #1;
    check("start_busy", busy_o, 1);
    check("start_valid", valid_o, 1);
    check("start_done_drop", done_o, 0);
  endtask

  task automatic feed(input int mode, input int n_stop, input bit inject, output int cyc);
    int nx;
    nx = 0; cyc = 0;
    for (int t = 0; t < 200 && nx < n_stop; t++) begin
      if (t > 0) @(negedge clk_i);
      ready_i   = (mode == 0) ? 1'b1 : 1'(t % 2);
      start_i   = inject && (t == 2);
      ld_v_i    = inject && (t == 2);
      ld_b_i    = 1'b0; ld_addr_i = 2'd0; ld_data_i = 8'd9;
      #1;
      check("feed_valid", valid_o, 1);
      check("feed_data", data_o, q_feed[0]);
      cyc++;
      if (ready_i) begin
        void'(q_feed.pop_front());
        nx++;
      end
    end
    if (nx < n_stop) check("feed_timeout", nx, n_stop);
    @(negedge clk_i);
    start_i = 1'b0; ld_v_i = 1'b0;
  endtask

  task automatic wait_flush(input int idle_low);
    int cf;
    cf = ((idle_low > 1) ? idle_low : 1) + 1;
    for (int c = 0; c <= cf; c++) begin
      if (c > 0) @(negedge clk_i);
      idle_i  = (c >= idle_low);
      valid_i = 1'b1;
      data_i  = 8'hEE;
      #1;
      check("flush_timing", flush_o, (c == cf));
      if (c == 0) check("wait_valid_low", valid_o, 0);
      if (c == cf) check("flush_no_yumi", yumi_o, 0);
    end
    @(negedge clk_i);
    idle_i = 1'b1; valid_i = 1'b0;
  endtask

  task automatic collect(input int gap);
    int nx;
    nx = 0;
    for (int t = 0; t < 100 && nx < H*W; t++) begin
      if (t > 0) @(negedge clk_i);
      valid_i = ((t % gap) == gap - 1);
      data_i  = valid_i ? q_res[0] : 8'hEE;
      #1;
      check("collect_yumi", yumi_o, valid_i);
      check("collect_done_low", done_o, 0);
      if (valid_i) begin
        void'(q_res.pop_front());
        nx++;
      end
    end
    if (nx < H*W) check("collect_timeout", nx, H*W);
    @(negedge clk_i);
    valid_i = 1'b1; data_i = 8'hEE;
    #1;
    check("done_rise", done_o, 1);
    check("done_busy_low", busy_o, 0);
    check("done_no_yumi", yumi_o, 0);
    valid_i = 1'b0;
  endtask

  task automatic read_results();
    for (int i = 0; i < H*W; i++) begin
      rd_addr_i = 2'(i);
      #1;
      check("result_read", rd_data_o, exp_c[i]);
    end
  endtask

  initial begin
    int cyc;
    ma = '{'{1, 2}, '{3, 4}};
    mb = '{'{1, 2}, '{3, 4}};
    reset_ni = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_yumi", yumi_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;

    // Reference multiply
    load_all(1'b0);
    push_expected();
    do_start();
    check_start();
    feed(0, 8, 1'b0, cyc);
    check("feed_len_min", cyc, K*(W+H));
    wait_flush(0);
    collect(1);
    read_results();

    // start/load attempts while busy are ignored
    push_expected();
    do_start();
    check_start();
    feed(0, 8, 1'b1, cyc);
    wait_flush(0);
    collect(1);
    read_results();

    // Backpressure with idle held low for 10 cycles; A[0] must still be 1
    push_expected();
    do_start();
    check_start();
    feed(1, 8, 1'b0, cyc);
    check("feed_len_bp", (cyc >= 16), 1);
    wait_flush(10);
    collect(1);
    read_results();

    // Slow drain
    push_expected();
    do_start();
    check_start();
    feed(0, 8, 1'b0, cyc);
    wait_flush(0);
    collect(3);
    read_results();

    // Reset mid-FEED after 3 transfers
    push_expected();
    do_start();
    check_start();
    feed(0, 3, 1'b0, cyc);
    valid_i = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_flush", flush_o, 0);
    check("midrst_yumi", yumi_o, 0);
    check("midrst_data", data_o, 0);
    rd_addr_i = 2'd0;
    #1;
    check("midrst_rd_cleared", rd_data_o, 0);
    q_feed.delete();
    q_res.delete();
    @(negedge clk_i);
    valid_i  = 1'b0;
    reset_ni = 1'b1;
    #1;
    check("post_rst_idle", busy_o, 0);
    push_expected();
    load_all(1'b1);
    check_start();
    feed(0, 8, 1'b0, cyc);
    wait_flush(0);
    collect(1);
    read_results();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
